// File: rtl/rv32i_types.sv
// Shared RV32I types plus the request record and state encoding used by the
// two-port memory arbiter.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_A,
    SERVE_B
  } arb_state_t;

  typedef struct packed {
    rv32i_word   address;
    logic        read;
    logic        write;
    logic [3:0]  wmask;
    rv32i_word   wdata;
  } arb_req_t;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational grant selection between the instruction (A) and data (B) ports:
// a lone request wins, ties go to B when fixed-priority, else to the port not granted last.
module arb_rr_pick
  import rv32i_types::*;
#(
  parameter bit FIXED_PRIORITY_B = 1'b0
) (
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic last_grant_i,
  output logic grant_a_o,
  output logic grant_b_o
);

  always_comb begin
    grant_b_o = req_b_i & (~req_a_i | FIXED_PRIORITY_B | (last_grant_i == GRANT_A));
    grant_a_o = req_a_i & ~grant_b_o;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-to-one arbiter serializing the CPU instruction and data ports onto one
// physical memory port; each granted request is latched until pmem_resp.
module mem_arbiter
  import rv32i_types::*;
#(
  parameter bit FIXED_PRIORITY_B = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_a,
  input  logic [31:0] address_a,
  output logic        resp_a,
  output logic [31:0] rdata_a,
  input  logic        read_b,
  input  logic        write,
  input  logic [3:0]  wmask,
  input  logic [31:0] address_b,
  input  logic [31:0] wdata,
  output logic        resp_b,
  output logic [31:0] rdata_b,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [3:0]  pmem_wmask,
  output logic [31:0] pmem_address,
  output logic [31:0] pmem_wdata,
  input  logic        pmem_resp,
  input  logic [31:0] pmem_rdata
);

  arb_state_t state_q;
  arb_req_t   req_q;
  logic       last_grant_q;
  logic       grant_a;
  logic       grant_b;

  arb_rr_pick #(
    .FIXED_PRIORITY_B(FIXED_PRIORITY_B)
  ) u_pick (
    .req_a_i      (read_a),
    .req_b_i      (read_b | write),
    .last_grant_i (last_grant_q),
    .grant_a_o    (grant_a),
    .grant_b_o    (grant_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_q        <= '0;
      last_grant_q <= GRANT_A;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_b) begin
            // A simultaneous read+write on B is illegal; the write wins.
            req_q <= '{address: address_b, read: read_b & ~write, write: write,
                       wmask: wmask, wdata: wdata};
            last_grant_q <= GRANT_B;
            state_q      <= SERVE_B;
          end else if (grant_a) begin
            req_q <= '{address: address_a, read: 1'b1, write: 1'b0,
                       wmask: 4'b0000, wdata: 32'h0};
            last_grant_q <= GRANT_A;
            state_q      <= SERVE_A;
          end
        end
        SERVE_A, SERVE_B: begin
          if (pmem_resp) begin
            req_q.read  <= 1'b0;
            req_q.write <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          req_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The memory port is driven purely from latched state so it cannot glitch.
  assign pmem_read    = req_q.read;
  assign pmem_write   = req_q.write;
  assign pmem_wmask   = req_q.wmask;
  assign pmem_address = req_q.address;
  assign pmem_wdata   = req_q.wdata;

  assign resp_a  = pmem_resp & (state_q == SERVE_A);
  assign resp_b  = pmem_resp & (state_q == SERVE_B);
  assign rdata_a = pmem_rdata;
  assign rdata_b = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin instance and a fixed-priority
// instance share stimulus and the memory response handshake.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_a;
  logic [31:0] address_a;
  logic        read_b;
  logic        write;
  logic [3:0]  wmask;
  logic [31:0] address_b;
  logic [31:0] wdata;
  logic        pmem_resp;
  logic [31:0] pmem_rdata;

  logic        resp_a, resp_b, pmem_read, pmem_write;
  logic [31:0] rdata_a, rdata_b, pmem_address, pmem_wdata;
  logic [3:0]  pmem_wmask;

  logic        fp_resp_a, fp_resp_b, fp_pmem_read, fp_pmem_write;
  logic [31:0] fp_rdata_a, fp_rdata_b, fp_pmem_address, fp_pmem_wdata;
  logic [3:0]  fp_pmem_wmask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.FIXED_PRIORITY_B(1'b0)) u_dut (
    .clk(clk), .rst(rst),
    .read_a(read_a), .address_a(address_a), .resp_a(resp_a), .rdata_a(rdata_a),
    .read_b(read_b), .write(write), .wmask(wmask), .address_b(address_b),
    .wdata(wdata), .resp_b(resp_b), .rdata_b(rdata_b),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wmask(pmem_wmask),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  mem_arbiter #(.FIXED_PRIORITY_B(1'b1)) u_dut_fp (
    .clk(clk), .rst(rst),
    .read_a(read_a), .address_a(address_a), .resp_a(fp_resp_a), .rdata_a(fp_rdata_a),
    .read_b(read_b), .write(write), .wmask(wmask), .address_b(address_b),
    .wdata(wdata), .resp_b(fp_resp_b), .rdata_b(fp_rdata_b),
    .pmem_read(fp_pmem_read), .pmem_write(fp_pmem_write), .pmem_wmask(fp_pmem_wmask),
    .pmem_address(fp_pmem_address), .pmem_wdata(fp_pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    read_a = 1'b0; address_a = '0; read_b = 1'b0; write = 1'b0;
    wmask = '0; address_b = '0; wdata = '0; pmem_resp = 1'b0; pmem_rdata = '0;
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_pmem_read", {31'b0, pmem_read}, 32'd0);
    chk("rst_pmem_write", {31'b0, pmem_write}, 32'd0);
    chk("rst_pmem_address", pmem_address, 32'h0);
    chk("rst_pmem_wmask", {28'b0, pmem_wmask}, 32'd0);
    chk("rst_resp", {30'b0, resp_a, resp_b}, 32'd0);
    cyc();
    rst = 1'b0;
  endtask

  // Waits (bounded) for a memory request, answers it with a one-cycle pmem_resp
  // and checks which port of each arbiter completes.
  task automatic serve(input string tag, input logic [31:0] exp_addr,
                       input logic [31:0] exp_fp_addr, input logic exp_b,
                       input logic exp_fp_b, input logic [31:0] rd);
    int n;
    n = 0;
    @(negedge clk);
    while (!(pmem_read | pmem_write) && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_started"}, {31'b0, (n < 8)}, 32'd1);
    chk({tag, "_addr"}, pmem_address, exp_addr);
    chk({tag, "_fp_addr"}, fp_pmem_address, exp_fp_addr);
    pmem_resp  = 1'b1;
    pmem_rdata = rd;
    #1;
    chk({tag, "_resp_ab"}, {30'b0, resp_a, resp_b}, {30'b0, ~exp_b, exp_b});
    chk({tag, "_fp_resp_ab"}, {30'b0, fp_resp_a, fp_resp_b}, {30'b0, ~exp_fp_b, exp_fp_b});
    chk({tag, "_rdata"}, exp_b ? rdata_b : rdata_a, rd);
    $display("txn %s port=%s addr=%h fp_addr=%h", tag, exp_b ? "B" : "A",
             pmem_address, fp_pmem_address);
    @(posedge clk);
    #1;
    pmem_resp = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Single A read, address changed mid-transaction.
    read_a = 1'b1; address_a = 32'h60;
    @(negedge clk); chk("a_c0_idle", {31'b0, pmem_read}, 32'd0);
    cyc(); @(negedge clk);
    chk("a_c1_read", {31'b0, pmem_read}, 32'd1);
    chk("a_c1_addr", pmem_address, 32'h60);
    cyc(); address_a = 32'h80; @(negedge clk);
    chk("a_c2_hold_addr", pmem_address, 32'h60);
    chk("a_c2_no_resp", {31'b0, resp_a}, 32'd0);
    cyc(); pmem_resp = 1'b1; pmem_rdata = 32'h00500093; @(negedge clk);
    chk("a_c3_resp", {30'b0, resp_a, resp_b}, 32'b10);
    chk("a_c3_rdata", rdata_a, 32'h00500093);
    chk("a_c3_read", {31'b0, pmem_read}, 32'd1);
    $display("txn single_a addr=%h rdata=%h", pmem_address, rdata_a);
    cyc(); pmem_resp = 1'b0; read_a = 1'b0; @(negedge clk);
    chk("a_c4_idle", {30'b0, resp_a, pmem_read}, 32'd0);

    // Masked B write.
    cyc(); write = 1'b1; address_b = 32'h104; wmask = 4'b0011; wdata = 32'hDEADBEEF;
    @(negedge clk); chk("w_c0_idle", {31'b0, pmem_write}, 32'd0);
    cyc(); @(negedge clk);
    chk("w_c1_write", {30'b0, pmem_write, pmem_read}, 32'b10);
    chk("w_c1_wmask", {28'b0, pmem_wmask}, 32'h3);
    chk("w_c1_wdata", pmem_wdata, 32'hDEADBEEF);
    chk("w_c1_addr", pmem_address, 32'h104);
    cyc(); pmem_resp = 1'b1; @(negedge clk);
    chk("w_c2_resp", {30'b0, resp_a, resp_b}, 32'b01);
    chk("w_c2_read", {31'b0, pmem_read}, 32'd0);
    $display("txn masked_write addr=%h wdata=%h", pmem_address, pmem_wdata);
    cyc(); pmem_resp = 1'b0; write = 1'b0; wmask = '0; @(negedge clk);
    chk("w_c3_idle", {30'b0, resp_b, pmem_write}, 32'd0);

    // Tie right after reset: B first, then A after one idle bubble.
    do_reset();
    read_a = 1'b1; read_b = 1'b1; address_a = 32'h200; address_b = 32'h300;
    serve("tie_first", 32'h300, 32'h300, 1'b1, 1'b1, 32'h11111111);
    read_b = 1'b0;
    @(negedge clk); chk("tie_bubble", {31'b0, pmem_read}, 32'd0);
    cyc(); @(negedge clk);
    chk("tie_a_granted", {31'b0, pmem_read}, 32'd1);
    serve("tie_second", 32'h200, 32'h200, 1'b0, 1'b0, 32'h22222222);

    // Sustained contention: round-robin alternates, fixed priority keeps B.
    read_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic pick_b;
      pick_b = (i % 2 == 0);
      serve($sformatf("rr%0d", i), pick_b ? 32'h300 : 32'h200, 32'h300,
            pick_b, 1'b1, 32'h1000 + i);
    end
    read_b = 1'b0;
    serve("b_dropped", 32'h200, 32'h200, 1'b0, 1'b0, 32'h33333333);
    read_a = 1'b0;

    // Reset during SERVE_B, then a stray pmem_resp.
    do_reset();
    read_b = 1'b1; address_b = 32'h400;
    cyc(); @(negedge clk);
    chk("mr_c1_read", {31'b0, pmem_read}, 32'd1);
    cyc(); rst = 1'b1; @(negedge clk);
    chk("mr_c2_read", {31'b0, pmem_read}, 32'd1);
    cyc(); rst = 1'b0; read_b = 1'b0; @(negedge clk);
    chk("mr_c3_pmem_ops", {30'b0, pmem_read, pmem_write}, 32'd0);
    chk("mr_c3_pmem_addr", pmem_address, 32'h0);
    chk("mr_c3_fp_ops", {30'b0, fp_pmem_read, fp_pmem_write}, 32'd0);
    pmem_resp = 1'b1; #1;
    chk("mr_stray_resp", {30'b0, resp_a, resp_b}, 32'd0);
    chk("mr_stray_fp_resp", {30'b0, fp_resp_a, fp_resp_b}, 32'd0);
    $display("txn reset_mid stray_resp resp_a=%b resp_b=%b", resp_a, resp_b);
    cyc(); pmem_resp = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
